// File: rtl/deser4_1.sv
// Lane demultiplexer: steers serial bits into lanes and assembles a WIDTH-bit word.
// Latency: out_valid rises one edge after the final-lane bit is accepted.
// Backpressure: stalls only on the final lane while the previous word is unconsumed.
module deser4_1 #(
    parameter int WIDTH = 4,
    parameter int SELW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             sof,
    output logic             in_ready,
    output logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    localparam logic [SELW-1:0] LAST_LANE = SELW'(WIDTH - 1);

    logic [SELW-1:0]  sel_q, sel_d;
    logic [WIDTH-2:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;

    logic accept;
    logic xfer;

    // Only the final lane has to wait for the held word to drain.
    assign in_ready = !(sel_q == LAST_LANE && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;

    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

    // Next-state: lane steering, word completion, resync on sof, output handshake.
    always_comb begin
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;

        // A consumed word drops valid unless a new word lands in the same cycle.
        if (xfer) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (sof) begin
                // sof forces lane 0; any partial word in progress is thrown away.
                shadow_d[0] = in;
                sel_d       = SELW'(1);
                err_d       = (sel_q != '0);
            end else if (sel_q == LAST_LANE) begin
                out_d       = {in, shadow_q};
                out_valid_d = 1'b1;
                sel_d       = '0;
            end else begin
                shadow_d[sel_q] = in;
                sel_d           = sel_q + SELW'(1);
            end
        end
    end

    // State registers with synchronous reset; reset drops partial and held words silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule
